fnd_scan_reader: RTL and testbench

- Receive-side counterpart to the 4-digit FND scan driver.
- Samples the multiplexed common-select lines (fnd_com) and segment lines (fnd_data) and decodes each segment pattern back to a 4-bit digit code.
- Assembles one complete scan round into a 4-digit frame.
- Used for on-chip readback of displayed humidity/temperature values, e.g. feeding the UART TX path and self-check logic.

---
 rtl/fnd_scan_reader.sv | 197 +++++++++++++++++++
 tb/tb_fnd_scan_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_reader.sv
// fnd_scan_reader: reads back a 4-digit multiplexed FND scan. It samples the
// active-low common selects and segments, decodes each settled digit, and
// publishes one 4-digit frame per complete scan round.
module fnd_scan_reader #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STALL_CYCLES  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        com_err,
    output logic        scan_stall
);

    localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t state, state_nxt;

    logic [3:0]         com_q, com_p;
    logic [7:0]         data_q, data_p;
    logic               com_chg, data_chg, com_valid;
    logic [1:0]         idx;
    logic [7:0]         settle_cnt, settle_cnt_nxt;
    logic               capture, com_err_nxt;
    logic [15:0]        slot_dig;
    logic [3:0]         slot_dp;
    logic [3:0]         mask, mask_base;
    logic [STALL_W-1:0] stall_cnt;

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        logic [3:0] val;
        case (seg)
            7'h40:   val = 4'h0;
            7'h79:   val = 4'h1;
            7'h24:   val = 4'h2;
            7'h30:   val = 4'h3;
            7'h19:   val = 4'h4;
            7'h12:   val = 4'h5;
            7'h02:   val = 4'h6;
            7'h78:   val = 4'h7;
            7'h00:   val = 4'h8;
            7'h10:   val = 4'h9;
            7'h7F:   val = 4'hE;
            default: val = 4'hF;
        endcase
        return val;
    endfunction

    // Input register plus a one-cycle history used for change detection.
    // Selects reset to all-high so leaving reset never looks like a com change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            com_q  <= '1;
            com_p  <= '1;
            data_q <= '1;
            data_p <= '1;
        end else begin
            com_q  <= fnd_com;
            com_p  <= com_q;
            data_q <= fnd_data;
            data_p <= data_q;
        end
    end

    assign com_chg   = (com_q != com_p);
    assign data_chg  = (data_q != data_p);
    assign com_valid = $onehot(~com_q);

    // Slot index of the currently selected digit.
    always_comb begin
        idx = 2'd0;
        case (com_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // FSM state register and settle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            com_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            com_err    <= com_err_nxt;
        end
    end

    // Next-state logic: wait for a valid select, require a stable window, capture once.
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        capture        = 1'b0;
        com_err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (com_valid) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = '0;
                end else if (com_chg) begin
                    com_err_nxt = 1'b1;
                end
            end
            SETTLE: begin
                if (com_chg || data_chg) begin
                    settle_cnt_nxt = '0;
                    if (!com_valid) begin
                        state_nxt   = IDLE;
                        com_err_nxt = 1'b1;
                    end
                end else if (settle_cnt == SETTLE_LAST) begin
                    capture        = 1'b1;
                    settle_cnt_nxt = '0;
                    state_nxt      = HOLD;
                end else begin
                    settle_cnt_nxt = settle_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (com_chg) begin
                    settle_cnt_nxt = '0;
                    if (com_valid) begin
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt   = IDLE;
                        com_err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A full mask is consumed this cycle, so a same-cycle capture starts a fresh round.
    assign mask_base = (mask == 4'hF) ? 4'h0 : mask;

    // Slot capture, mask tracking and frame publication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_dig    <= '1;
            slot_dp     <= '0;
            mask        <= '0;
            digits      <= '1;
            dp          <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (mask == 4'hF) begin
                digits      <= slot_dig;
                dp          <= slot_dp;
                frame_valid <= 1'b1;
                seg_err     <= (slot_dig[3:0] == 4'hF) || (slot_dig[7:4] == 4'hF) ||
                               (slot_dig[11:8] == 4'hF) || (slot_dig[15:12] == 4'hF);
            end
            if (capture) begin
                slot_dig[{idx, 2'b00} +: 4] <= seg_decode(data_q[6:0]);
                slot_dp[idx]                <= ~data_q[7];
                mask                        <= mask_base | ~com_q;
            end else begin
                mask <= mask_base;
            end
        end
    end

    // Stall counter: cleared by any select change, saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (com_chg) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    assign scan_stall = (stall_cnt == STALL_MAX);

endmodule

// File: tb/tb_fnd_scan_reader.sv
// Self-checking bench for fnd_scan_reader: table-driven scans plus hand
// sequences for latency, glitching, invalid selects, stall and reset.
module tb_fnd_scan_reader;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned STALL  = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        frame_valid, seg_err, com_err, scan_stall;

    fnd_scan_reader #(
        .SETTLE_CYCLES(SETTLE),
        .STALL_CYCLES(STALL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fnd_com(fnd_com),
        .fnd_data(fnd_data),
        .digits(digits),
        .dp(dp),
        .frame_valid(frame_valid),
        .seg_err(seg_err),
        .com_err(com_err),
        .scan_stall(scan_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        err;
    } frame_t;

    typedef struct packed {
        logic [31:0] segs;   // {digit3, digit2, digit1, digit0} segment bytes
        frame_t      exp;
    } vec_t;

    frame_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int com_err_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] c, input logic [7:0] d, input int n);
        fnd_com  = c;
        fnd_data = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] segs);
        logic [3:0] sel;
        for (int i = 0; i < 4; i++) begin
            sel = 4'b0001 << i;
            hold(~sel, segs[i*8 +: 8], 10);
        end
    endtask

    // Frame monitor: pops the scoreboard on every frame_valid pulse.
    always @(negedge clk) begin
        frame_t e;
        if (!reset) begin
            if (frame_valid) begin
                frames_seen++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got digits %0h expected no frame", digits);
                end else begin
                    e = sb_q.pop_front();
                    check("frame_digits", 32'(digits), 32'(e.digits));
                    check("frame_dp", 32'(dp), 32'(e.dp));
                    check("frame_seg_err", 32'(seg_err), 32'(e.err));
                end
            end
            if (com_err) com_err_seen++;
        end
    end

    initial begin
        vec_t vecs[6];
        int   f0, c0, lat;

        vecs[0] = '{segs: 32'hB0A4F9C0, exp: '{digits: 16'h3210, dp: 4'b0000, err: 1'b0}};
        vecs[1] = '{segs: 32'hB024F9C0, exp: '{digits: 16'h3210, dp: 4'b0100, err: 1'b0}};
        vecs[2] = '{segs: 32'hB0A4FFC0, exp: '{digits: 16'h32E0, dp: 4'b0000, err: 1'b0}};
        vecs[3] = '{segs: 32'hB0A4AAC0, exp: '{digits: 16'h32F0, dp: 4'b0000, err: 1'b1}};
        vecs[4] = '{segs: 32'hF8829299, exp: '{digits: 16'h7654, dp: 4'b0000, err: 1'b0}};
        vecs[5] = '{segs: 32'hC07F9000, exp: '{digits: 16'h0E98, dp: 4'b0101, err: 1'b0}};

        reset    = 1'b1;
        fnd_com  = 4'hF;
        fnd_data = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits), 32'h0000FFFF);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_seg_err", 32'(seg_err), 32'h0);
        check("rst_com_err", 32'(com_err), 32'h0);
        check("rst_scan_stall", 32'(scan_stall), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven full scans.
        for (int v = 0; v < 6; v++) begin
            sb_q.push_back(vecs[v].exp);
            scan(vecs[v].segs);
        end
        repeat (2) @(negedge clk);
        check("table_frames", 32'(frames_seen), 32'd6);
        check("table_no_com_err", 32'(com_err_seen), 32'd0);

        // Latency from the last digit's select to frame_valid.
        sb_q.push_back('{digits: 16'h3210, dp: 4'b0000, err: 1'b0});
        hold(4'b1110, 8'hC0, 10);
        hold(4'b1101, 8'hF9, 10);
        hold(4'b1011, 8'hA4, 10);
        fnd_com  = 4'b0111;
        fnd_data = 8'hB0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (frame_valid) break;
        end
        check("frame_latency", 32'(lat), 32'(SETTLE + 3));
        repeat (5) @(negedge clk);

        // Glitching segments after a select change must not be captured.
        sb_q.push_back('{digits: 16'h3240, dp: 4'b0000, err: 1'b0});
        hold(4'b1110, 8'hC0, 10);
        for (int k = 0; k < 4; k++) hold(4'b1101, (k % 2 == 0) ? 8'hF9 : 8'h99, 2);
        hold(4'b1101, 8'h99, 10);
        hold(4'b1011, 8'hA4, 10);
        hold(4'b0111, 8'hB0, 10);

        // Invalid selects pulse com_err and keep the partial mask.
        f0 = frames_seen;
        hold(4'b1110, 8'hC0, 10);
        hold(4'b1101, 8'hF9, 10);
        c0 = com_err_seen;
        hold(4'b1111, 8'hFF, 6);
        hold(4'b1100, 8'hFF, 6);
        check("com_err_pulses", 32'(com_err_seen - c0), 32'd2);
        check("no_frame_on_invalid", 32'(frames_seen - f0), 32'd0);
        sb_q.push_back('{digits: 16'h3210, dp: 4'b0000, err: 1'b0});
        hold(4'b1011, 8'hA4, 10);
        hold(4'b0111, 8'hB0, 10);
        check("resume_frame", 32'(frames_seen - f0), 32'd1);

        // Stall detection; the stall does not clear the mask.
        sb_q.push_back('{digits: 16'h3210, dp: 4'b0000, err: 1'b0});
        hold(4'b1110, 8'hC0, 290);
        check("stall_not_yet", 32'(scan_stall), 32'd0);
        repeat (20) @(negedge clk);
        check("stall_set", 32'(scan_stall), 32'd1);
        fnd_com  = 4'b1101;
        fnd_data = 8'hF9;
        @(negedge clk);
        check("stall_held_one_cycle", 32'(scan_stall), 32'd1);
        @(negedge clk);
        check("stall_cleared", 32'(scan_stall), 32'd0);
        hold(4'b1101, 8'hF9, 8);
        hold(4'b1011, 8'hA4, 10);
        hold(4'b0111, 8'hB0, 10);

        // Reset mid-frame discards the partial mask.
        hold(4'b1110, 8'hC0, 10);
        hold(4'b1101, 8'hF9, 10);
        reset = 1'b1;
        #1;
        check("async_rst_digits", 32'(digits), 32'h0000FFFF);
        check("async_rst_scan_stall", 32'(scan_stall), 32'h0);
        fnd_com  = 4'hF;
        fnd_data = 8'hFF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        f0 = frames_seen;
        sb_q.push_back('{digits: 16'h3210, dp: 4'b0000, err: 1'b0});
        scan(32'hB0A4F9C0);
        repeat (5) @(negedge clk);
        check("post_reset_one_frame", 32'(frames_seen - f0), 32'd1);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
